// File: rtl/tile_board_init.sv
// Writes the 8 tile pairs, Fisher-Yates shuffles them with a 16-bit LFSR, then sets the cursor on tile 0.
// SHUFFLE=0: done 11+READ_LAT cycles after start; no backpressure: owns both RAM ports from start to done.
module tile_board_init #(
    parameter int READ_LAT = 2,
    parameter int SHUFFLE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] seed,
    output logic        busy,
    output logic        done,
    output logic [3:0]  addrA,
    output logic [3:0]  addrB,
    output logic [7:0]  writeA,
    output logic [7:0]  writeB,
    output logic        weA,
    output logic        weB,
    input  logic [7:0]  readA,
    input  logic [7:0]  readB
);
    localparam int CW = $clog2(READ_LAT + 2);

    typedef enum logic [2:0] {
        IDLE, FILL, SHUF_PICK, SHUF_WAIT, SHUF_WR, CUR_WAIT, CUR_WR, DONE
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [2:0]    k_q, k_d, k_inc;
    logic [3:0]    i_q, i_d, i_dec, r;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic [3:0]    addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic [7:0]    write_a_q, write_a_d, write_b_q, write_b_d;
    logic          we_a_q, we_a_d, we_b_q, we_b_d;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        i_d       = i_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        addr_a_d  = addr_a_q;
        addr_b_d  = addr_b_q;
        write_a_d = write_a_q;
        write_b_d = write_b_q;
        we_a_d    = 1'b0;
        we_b_d    = 1'b0;
        k_inc     = k_q + 3'd1;
        i_dec     = i_q - 4'd1;
        r         = lfsr_q[3:0];
        lfsr_d    = busy_q ? {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]}
                           : lfsr_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = FILL;
                    lfsr_d    = (seed == 16'h0000) ? 16'hACE1 : seed;
                    k_d       = 3'd0;
                    i_d       = 4'd15;
                    busy_d    = 1'b1;
                    addr_a_d  = 4'd0;
                    addr_b_d  = 4'd1;
                    write_a_d = 8'h00;
                    write_b_d = 8'h00;
                    we_a_d    = 1'b1;
                    we_b_d    = 1'b1;
                end
            end
            // Outputs are registered, so each FILL cycle sets up the next pair's write.
            FILL: begin
                if (k_q != 3'd7) begin
                    k_d       = k_inc;
                    addr_a_d  = {k_inc, 1'b0};
                    addr_b_d  = {k_inc, 1'b1};
                    write_a_d = {3'b000, k_inc, 2'b00};
                    write_b_d = {3'b000, k_inc, 2'b00};
                    we_a_d    = 1'b1;
                    we_b_d    = 1'b1;
                end else if (SHUFFLE != 0) begin
                    state_d = SHUF_PICK;
                end else begin
                    state_d  = CUR_WAIT;
                    cnt_d    = CW'(1);
                    addr_a_d = 4'd0;
                end
            end
            SHUF_PICK: begin
                if (r == i_q) begin
                    i_d = i_dec;
                    if (i_dec == 4'd0) begin
                        state_d  = CUR_WAIT;
                        cnt_d    = CW'(1);
                        addr_a_d = 4'd0;
                    end
                end else if (r < i_q) begin
                    addr_a_d = i_q;
                    addr_b_d = r;
                    state_d  = SHUF_WAIT;
                    cnt_d    = CW'(1);
                end
            end
            SHUF_WAIT: begin
                if (cnt_q == CW'(READ_LAT)) state_d = SHUF_WR;
                else                        cnt_d   = cnt_q + CW'(1);
            end
            SHUF_WR: begin
                write_a_d = readB;
                write_b_d = readA;
                we_a_d    = 1'b1;
                we_b_d    = 1'b1;
                i_d       = i_dec;
                if (i_dec == 4'd0) begin
                    // The swap write occupies the ports next cycle, so the cursor read starts one later.
                    state_d = CUR_WAIT;
                    cnt_d   = CW'(0);
                end else begin
                    state_d = SHUF_PICK;
                end
            end
            CUR_WAIT: begin
                addr_a_d = 4'd0;
                if (cnt_q == CW'(READ_LAT)) state_d = CUR_WR;
                else                        cnt_d   = cnt_q + CW'(1);
            end
            CUR_WR: begin
                write_a_d = readA | 8'h01;
                we_a_d    = 1'b1;
                state_d   = DONE;
            end
            DONE: begin
                if (!done_q) begin
                    done_d = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            lfsr_q    <= 16'hACE1;
            k_q       <= 3'd0;
            i_q       <= 4'd0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            addr_a_q  <= 4'd0;
            addr_b_q  <= 4'd0;
            write_a_q <= 8'h00;
            write_b_q <= 8'h00;
            we_a_q    <= 1'b0;
            we_b_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            k_q       <= k_d;
            i_q       <= i_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            addr_a_q  <= addr_a_d;
            addr_b_q  <= addr_b_d;
            write_a_q <= write_a_d;
            write_b_q <= write_b_d;
            we_a_q    <= we_a_d;
            we_b_q    <= we_b_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign addrA  = addr_a_q;
    assign addrB  = addr_b_q;
    assign writeA = write_a_q;
    assign writeB = write_b_q;
    assign weA    = we_a_q;
    assign weB    = we_b_q;

endmodule
